seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  4-digit time-multiplexed seven-segment driver. Downstream of the BCD counter stages:
//  consumes four packed BCD digits plus decimal points and drives the shared active-low
//  Seg/an bus of the board's 4-digit display. Each digit gets a refresh slot with a
//  dead-time to kill ghosting. Leading zeros can be blanked. Updates are tear-free (frame-aligned).
// PARAMETERS
//  DIV       100_000  clock cycles per digit slot (1 kHz/digit at 100 MHz Clk)
//  DivBits   17       width of slot counter; 2^DivBits > DIV-1
//  BLANK     1_000    dead-time cycles at start of each slot (all anodes off); BLANK < DIV
// PORTS
//  Clk     in   1   system clock, rising edge
//  Clr     in   1   asynchronous reset, active-high
//  Digits  in   16  BCD digits; [15:12]=digit3 (leftmost) ... [3:0]=digit0 (rightmost)
//  Dp      in   4   decimal point request per digit, 1=on; Dp[k] -> digit k
//  Load    in   1   1-cycle strobe: capture Digits/Dp into pending register
//  Lzb     in   1   1 = leading-zero blanking enabled
//  En      in   1   1 = display on; 0 = all anodes off (timing keeps running)
//  Seg     out  7   segments gfedcba, active-low
//  DpOut   out  1   decimal point segment, active-low
//  an      out  4   anodes, active-low; an[k] -> digit k
//  Slot    out  2   index of slot currently on the bus (aligned with an/Seg)
// BEHAVIOUR
//  Reset (async, Clr=1): cnt=0, slot=0, pending=active=0, pflag=0; an=4'b1111,
//   Seg=7'b1111111, DpOut=1, Slot=0. Clr mid-frame -> same values immediately.
//  Timing: cnt counts 0..DIV-1; at cnt==DIV-1: cnt<=0, slot<=slot+1 (3 wraps to 0).
//   Phase BLANK when cnt<BLANK, else SHOW. Two-phase FSM per slot: BLANK->SHOW at
//   cnt==BLANK-1; SHOW->BLANK(next slot) at cnt==DIV-1.
//  Outputs registered from pre-edge cnt/slot: 1 cycle latency. With DIV=8, BLANK=2,
//   after Clr release: edges 1-2 an=1111; 3-8 an=1110; 9-10 1111; 11-16 1101; ...
//   edges 27-32 an=0111; edge 33 starts slot0 again.
//  SHOW phase, slot k: an=~(1<<k) unless digit k blanked or En=0 (then an=1111).
//   Seg = decode(active digit k); DpOut=~activeDp[k]. BLANK phase / blanked / En=0:
//   Seg=7'b1111111, DpOut=1.
//  Decode: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//   6=0000010 7=1111000 8=0000000 9=0010000; 10-15 (invalid BCD) = 0111111 ("-").
//  Leading-zero blank (Lzb=1): digit k in {3,2,1} blanked iff digits 3..k all ==0
//   and activeDp[k]==0. Digit 0 never blanked. Invalid codes count as nonzero.
//  Load: pending<=Digits/Dp, pflag<=1. Transfer pending->active at frame boundary
//   (edge where cnt==DIV-1 and slot==3), pflag<=0. Load on that same edge: new
//   Digits/Dp go straight to active, pflag stays 0. Multiple Loads in a frame: last wins.
//  Lzb, En sampled every cycle (not frame-aligned).
//  Slot output = slot of the digit currently shown (registered, same latency as an).
// TESTING
//  1 DIV=8,BLANK=2, Load 16'h1234 before frame 0 -> edges 3-8 an=1110 Seg=0011001(4);
//    11-16 an=1101 Seg=0110000; 19-24 1011/0100100; 27-32 0111/1111001; Slot 0..3.
//  2 Load 16'h0007 with Lzb=1 -> only an=1110 ever asserts, Seg=1111000; Lzb=0 -> digits
//    3..1 show 1000000. Dp=4'b0100 with Lzb=1 -> digit2 shown (zero+DpOut=0), digit3 blank.
//  3 Load 16'h5555 mid-frame (slot1) -> remaining slots of that frame show old value;
//    new value from next slot0. Load on frame-boundary edge -> takes effect that frame.
//  4 Digits=16'h00AF -> digits 1,0 show 0111111; Lzb=1 blanks digits 3,2 only.
//  5 En=0 for one full frame -> an=1111, Seg=1111111 throughout; En=1 resumes at current
//    slot position (no counter restart).
//  6 Assert Clr during SHOW of slot2 -> same-instant an=1111, Seg=1111111, Slot=0;
//    after release, sequence restarts exactly as test 1 from edge 1.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver (active-low segments and anodes).
// Each slot begins with a dead-time. Digit updates take effect only on a frame boundary.
module seg7_scan_driver #(
    parameter int DIV     = 100_000,
    parameter int DivBits = 17,
    parameter int BLANK   = 1_000
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [15:0] Digits,
    input  logic [3:0]  Dp,
    input  logic        Load,
    input  logic        Lzb,
    input  logic        En,
    output logic [6:0]  Seg,
    output logic        DpOut,
    output logic [3:0]  an,
    output logic [1:0]  Slot
);

    typedef enum logic [0:0] {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

    localparam logic [DivBits-1:0] CntLast   = DivBits'(DIV - 1);
    localparam logic [DivBits-1:0] BlankLast = DivBits'(BLANK - 1);

    function automatic logic [6:0] bcd_decode(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b0111111;
        endcase
        return seg;
    endfunction

    logic [DivBits-1:0] cnt_r;
    logic [1:0]         slot_r;
    phase_t             phase_r;
    logic [15:0]        pending_r;
    logic [3:0]         pend_dp_r;
    logic               pflag_r;
    logic [15:0]        active_r;
    logic [3:0]         act_dp_r;
    logic [6:0]         seg_r;
    logic               dp_r;
    logic [3:0]         an_r;
    logic [1:0]         slot_out_r;

    logic [3:0] blank_s;
    logic       zero_run_s;
    logic [3:0] cur_digit_s;
    logic       cur_dp_s;
    logic       show_s;
    logic       frame_end_s;

    // Leading-zero blanking: a zero run from the leftmost digit hides digits unless their point is lit.
    always_comb begin
        zero_run_s = 1'b1;
        blank_s    = 4'b0000;
        for (int k = 3; k >= 1; k--) begin
            zero_run_s = zero_run_s & (active_r[4*k +: 4] == 4'd0);
            blank_s[k] = Lzb & zero_run_s & ~act_dp_r[k];
        end
    end

    // Select the digit for the slot currently being driven.
    always_comb begin
        cur_digit_s = 4'd0;
        cur_dp_s    = 1'b0;
        case (slot_r)
            2'd0:    begin cur_digit_s = active_r[3:0];   cur_dp_s = act_dp_r[0]; end
            2'd1:    begin cur_digit_s = active_r[7:4];   cur_dp_s = act_dp_r[1]; end
            2'd2:    begin cur_digit_s = active_r[11:8];  cur_dp_s = act_dp_r[2]; end
            2'd3:    begin cur_digit_s = active_r[15:12]; cur_dp_s = act_dp_r[3]; end
            default: begin cur_digit_s = 4'd0;            cur_dp_s = 1'b0;        end
        endcase
    end

    assign show_s      = (phase_r == PH_SHOW) & En & ~blank_s[slot_r];
    assign frame_end_s = (cnt_r == CntLast) & (slot_r == 2'd3);

    // Slot timing, blank/show phase FSM and registered bus outputs (one cycle behind cnt/slot).
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            cnt_r      <= '0;
            slot_r     <= 2'd0;
            phase_r    <= PH_BLANK;
            an_r       <= 4'b1111;
            seg_r      <= 7'b1111111;
            dp_r       <= 1'b1;
            slot_out_r <= 2'd0;
        end else begin
            if (cnt_r == CntLast) begin
                cnt_r  <= '0;
                slot_r <= slot_r + 2'd1;
            end else begin
                cnt_r  <= cnt_r + DivBits'(1);
                slot_r <= slot_r;
            end

            case (phase_r)
                PH_BLANK: begin
                    if (cnt_r == BlankLast) phase_r <= PH_SHOW;
                    else                    phase_r <= PH_BLANK;
                end
                PH_SHOW: begin
                    if (cnt_r == CntLast) phase_r <= PH_BLANK;
                    else                  phase_r <= PH_SHOW;
                end
                default: phase_r <= PH_BLANK;
            endcase

            slot_out_r <= slot_r;
            if (show_s) begin
                an_r  <= ~(4'b0001 << slot_r);
                seg_r <= bcd_decode(cur_digit_s);
                dp_r  <= ~cur_dp_s;
            end else begin
                an_r  <= 4'b1111;
                seg_r <= 7'b1111111;
                dp_r  <= 1'b1;
            end
        end
    end

    // Double-buffered digit data; a Load on the boundary edge bypasses the pending stage.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            pending_r <= 16'h0000;
            pend_dp_r <= 4'b0000;
            pflag_r   <= 1'b0;
            active_r  <= 16'h0000;
            act_dp_r  <= 4'b0000;
        end else begin
            if (frame_end_s && Load) begin
                active_r  <= Digits;
                act_dp_r  <= Dp;
                pending_r <= Digits;
                pend_dp_r <= Dp;
                pflag_r   <= 1'b0;
            end else if (frame_end_s && pflag_r) begin
                active_r <= pending_r;
                act_dp_r <= pend_dp_r;
                pflag_r  <= 1'b0;
            end else if (Load) begin
                pending_r <= Digits;
                pend_dp_r <= Dp;
                pflag_r   <= 1'b1;
            end else begin
                pflag_r <= pflag_r;
            end
        end
    end

    assign Seg   = seg_r;
    assign DpOut = dp_r;
    assign an    = an_r;
    assign Slot  = slot_out_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at DIV=8, BLANK=2: each frame is 32 edges, checked edge by edge.
module tb_seg7_scan_driver;

    logic        Clk;
    logic        Clr;
    logic [15:0] Digits;
    logic [3:0]  Dp;
    logic        Load;
    logic        Lzb;
    logic        En;
    logic [6:0]  Seg;
    logic        DpOut;
    logic [3:0]  an;
    logic [1:0]  Slot;

    int err_cnt = 0;
    int chk_cnt = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;

    seg7_scan_driver #(.DIV(8), .DivBits(3), .BLANK(2)) dut (
        .Clk(Clk), .Clr(Clr), .Digits(Digits), .Dp(Dp), .Load(Load),
        .Lzb(Lzb), .En(En), .Seg(Seg), .DpOut(DpOut), .an(an), .Slot(Slot)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Run one full frame; segs = {d3,d2,d1,d0}, dpo = active-low point per digit, blank = digit kept dark.
    task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] dpo,
                               input logic [3:0] blank, input int ld_e0, input logic [15:0] ld_v0,
                               input int ld_e1, input logic [15:0] ld_v1, input logic [3:0] ld_dp);
        for (int e = 0; e < 32; e++) begin
            int k;
            int pos;
            logic [3:0] exp_an;
            logic [6:0] exp_seg;
            logic       exp_dp;
            if (e == ld_e0) begin Load = 1'b1; Digits = ld_v0; Dp = ld_dp; end
            if (e == ld_e1) begin Load = 1'b1; Digits = ld_v1; Dp = ld_dp; end
            step();
            Load = 1'b0;
            k   = e / 8;
            pos = e % 8;
            if (pos < 2 || blank[k]) begin
                exp_an = 4'b1111; exp_seg = SB; exp_dp = 1'b1;
            end else begin
                exp_an  = ~(4'b0001 << k);
                exp_seg = segs[7*k +: 7];
                exp_dp  = dpo[k];
            end
            check_val($sformatf("%s an e%0d", tag, e), {28'd0, an}, {28'd0, exp_an});
            check_val($sformatf("%s seg e%0d", tag, e), {25'd0, Seg}, {25'd0, exp_seg});
            check_val($sformatf("%s dp e%0d", tag, e), {31'd0, DpOut}, {31'd0, exp_dp});
            check_val($sformatf("%s slot e%0d", tag, e), {30'd0, Slot}, k);
        end
    endtask

    initial begin
        Clr = 1'b1; Digits = 16'h0000; Dp = 4'b0000; Load = 1'b0; Lzb = 1'b0; En = 1'b1;
        #12;
        check_val("rst an", {28'd0, an}, 32'h0000_000F);
        check_val("rst seg", {25'd0, Seg}, 32'h0000_007F);
        check_val("rst dp", {31'd0, DpOut}, 32'd1);
        check_val("rst slot", {30'd0, Slot}, 32'd0);
        @(posedge Clk);
        #1;
        Clr = 1'b0;

        // Frame 0 shows cleared data; 1234 loaded mid-frame appears next frame.
        check_frame("f0", {S0, S0, S0, S0}, 4'b1111, 4'b0000, 3, 16'h1234, -1, 16'h0, 4'b0000);
        check_frame("f1", {S1, S2, S3, S4}, 4'b1111, 4'b0000, 9, 16'h0007, -1, 16'h0, 4'b0000);
        Lzb = 1'b1;
        check_frame("f2lzb", {S0, S0, S0, S7}, 4'b1111, 4'b1110, -1, 16'h0, -1, 16'h0, 4'b0000);
        Lzb = 1'b0;
        check_frame("f3", {S0, S0, S0, S7}, 4'b1111, 4'b0000, 20, 16'h0007, -1, 16'h0, 4'b0100);
        Lzb = 1'b1;
        // Digit2 has its point lit so it stays visible; boundary-edge load lands in the next frame.
        check_frame("f4dp", {S0, S0, S0, S7}, 4'b1011, 4'b1010, 31, 16'h1234, -1, 16'h0, 4'b0000);
        check_frame("f5", {S1, S2, S3, S4}, 4'b1111, 4'b0000, 12, 16'h5555, -1, 16'h0, 4'b0000);
        check_frame("f6", {S5, S5, S5, S5}, 4'b1111, 4'b0000, 2, 16'h9999, 20, 16'h00AF, 4'b0000);
        check_frame("f7inv", {S0, S0, SD, SD}, 4'b1111, 4'b1100, -1, 16'h0, -1, 16'h0, 4'b0000);
        Lzb = 1'b0;
        En  = 1'b0;
        check_frame("f8off", {S0, S0, SD, SD}, 4'b1111, 4'b1111, -1, 16'h0, -1, 16'h0, 4'b0000);
        En  = 1'b1;
        check_frame("f9on", {S0, S0, SD, SD}, 4'b1111, 4'b0000, -1, 16'h0, -1, 16'h0, 4'b0000);

        // Mid-frame reset while slot2 is lit.
        for (int i = 0; i < 20; i++) step();
        check_val("pre clr an", {28'd0, an}, 32'h0000_000B);
        Clr = 1'b1;
        #1;
        check_val("clr an", {28'd0, an}, 32'h0000_000F);
        check_val("clr seg", {25'd0, Seg}, 32'h0000_007F);
        check_val("clr dp", {31'd0, DpOut}, 32'd1);
        check_val("clr slot", {30'd0, Slot}, 32'd0);
        @(posedge Clk);
        #1;
        Clr = 1'b0;
        check_frame("rst6", {S0, S0, S0, S0}, 4'b1111, 4'b0000, -1, 16'h0, -1, 16'h0, 4'b0000);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
